// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer: deck geometry, LFSR mask,
// FSM state encoding and the index-to-card mapping.
package card_pkg;

    localparam int          DECK_SIZE = 52;
    localparam int          RANKS     = 13;
    localparam int          SUITS     = 4;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } dealer_state_t;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    // Suit boundaries at 13/26/39 stand in for a divide/modulo by 13.
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t      c;
        logic [3:0] r;
        if (idx >= 6'd39) begin
            c.suit = 2'd3;
            r      = 4'(idx - 6'd39);
        end else if (idx >= 6'd26) begin
            c.suit = 2'd2;
            r      = 4'(idx - 6'd26);
        end else if (idx >= 6'd13) begin
            c.suit = 2'd1;
            r      = 4'(idx - 6'd13);
        end else begin
            c.suit = 2'd0;
            r      = idx[3:0];
        end
        c.rank = r + 4'd1;
        return c;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/response bundle between the dealer and its consumer, plus the FSM
// state for observation.
interface card_dealer_if;
    import card_pkg::*;

    // draw_req is a one-cycle pulse honoured only while the dealer is idle;
    // each honoured request is answered by exactly one draw_ack or draw_err
    // pulse unless shuffle arrives first, in which case neither is issued.
    logic          shuffle;
    logic          draw_req;
    logic          draw_ack;
    logic          draw_err;
    logic [5:0]    card_idx;
    logic [3:0]    card_rank;
    logic [1:0]    card_suit;
    logic [5:0]    cards_left;
    logic          deck_empty;
    logic          busy;
    dealer_state_t state;

    modport master (
        output shuffle, draw_req,
        input  draw_ack, draw_err, card_idx, card_rank, card_suit,
        input  cards_left, deck_empty, busy, state
    );

    modport slave (
        input  shuffle, draw_req,
        output draw_ack, draw_err, card_idx, card_rank, card_suit,
        output cards_left, deck_empty, busy, state
    );

endinterface

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Galois LFSR; only reset reloads the seed.
module lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= SEED;
        else     value <= (value >> 1) ^ (value[0] ? MASK : 16'h0000);
    end

endmodule

// File: rtl/card_dealer.sv
// One deck drawn without replacement: random start index from the LFSR, then
// a linear probe over the used-card bitmap until a free card is found.
module card_dealer
    import card_pkg::*;
#(
    parameter int          DECK_SIZE = 52,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    card_dealer_if.slave bus
);

    localparam logic [5:0] DECK_CNT = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    dealer_state_t          state_q, state_d;
    logic [DECK_SIZE-1:0]   used;
    logic [5:0]             cand;
    logic [5:0]             left_q;
    logic [15:0]            lfsr;
    logic [5:0]             lfsr_fold;
    logic                   lfsr_unused;
    logic                   cand_free;
    logic                   start_search, take_card, refuse, clear_deck;
    card_t                  picked;
    logic                   ack_q, err_q, busy_q, empty_q;
    logic [5:0]             idx_q;
    logic [3:0]             rank_q;
    logic [1:0]             suit_q;

    lfsr16 #(.SEED(LFSR_SEED), .MASK(LFSR_MASK)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:6];
    assign lfsr_fold   = (lfsr[5:0] >= DECK_CNT) ? lfsr[5:0] - DECK_CNT : lfsr[5:0];
    assign cand_free   = ~used[cand];
    assign picked      = idx_to_card(cand);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        start_search = 1'b0;
        take_card    = 1'b0;
        refuse       = 1'b0;
        clear_deck   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.shuffle) begin
                    clear_deck = 1'b1;
                end else if (bus.draw_req) begin
                    if (left_q == 6'd0) begin
                        refuse = 1'b1;
                    end else begin
                        start_search = 1'b1;
                        state_d      = SEARCH;
                    end
                end
            end
            SEARCH: begin
                // Shuffle outranks a probe that would have succeeded this cycle.
                if (bus.shuffle) begin
                    clear_deck = 1'b1;
                    state_d    = IDLE;
                end else if (cand_free) begin
                    take_card = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used    <= '0;
            left_q  <= DECK_CNT;
            cand    <= 6'd0;
            idx_q   <= 6'd0;
            rank_q  <= 4'd0;
            suit_q  <= 2'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            ack_q  <= take_card;
            err_q  <= refuse;
            busy_q <= (state_d == SEARCH);
            if (clear_deck) begin
                used    <= '0;
                left_q  <= DECK_CNT;
                empty_q <= 1'b0;
            end else if (take_card) begin
                used[cand] <= 1'b1;
                left_q     <= left_q - 6'd1;
                empty_q    <= (left_q == 6'd1);
                idx_q      <= cand;
                rank_q     <= picked.rank;
                suit_q     <= picked.suit;
            end
            if (start_search)
                cand <= lfsr_fold;
            else if (state_q == SEARCH && !cand_free)
                cand <= (cand == LAST_IDX) ? 6'd0 : cand + 6'd1;
        end
    end

    assign bus.draw_ack   = ack_q;
    assign bus.draw_err   = err_q;
    assign bus.card_idx   = idx_q;
    assign bus.card_rank  = rank_q;
    assign bus.card_suit  = suit_q;
    assign bus.cards_left = left_q;
    assign bus.deck_empty = empty_q;
    assign bus.busy       = busy_q;
    assign bus.state      = state_q;

endmodule
